cell_pos_reader: RTL and testbench

- Sits directly downstream of a single-port cell position RAM (2-cycle read latency, word 0 = particle count, words 1..N = {posz,posy,posx}).
- On start, reads the count word, then streams that cell's N particle positions to the force-evaluation pipeline over a valid/ready interface.
- Absorbs consumer backpressure through a credit-limited output FIFO.
- Drives the RAM read port only; never writes the RAM.

---
 rtl/cell_pos_reader_if.sv | 24 ++
 rtl/cell_pos_reader.sv | 176 +++++++++++++++++
 tb/tb_cell_pos_reader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cell_pos_reader_if.sv
// Particle position stream from the cell reader to the force-evaluation pipeline.
// The master presents positions; the slave accepts them with out_ready.
interface cell_pos_reader_if #(
   parameter int DATA_WIDTH = 96
);
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_pos;
   logic                  out_last;

   modport master (
      output out_valid,
      output out_pos,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_pos,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/cell_pos_reader.sv
// Reads one cell's particle count and positions from a 2-cycle-latency RAM and
// streams them out through a small credit-limited FIFO.
module cell_pos_reader #(
   parameter int DATA_WIDTH   = 96,
   parameter int PARTICLE_NUM = 220,
   parameter int ADDR_WIDTH   = 8,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_rden,
   output logic                  mem_wren,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] mem_q,
   cell_pos_reader_if.master     pos_out,
   output logic [ADDR_WIDTH-1:0] particle_cnt,
   output logic                  busy,
   output logic                  done
);

   localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_WIDTH = $clog2(FIFO_DEPTH + 1);
   localparam int CRD_WIDTH = OCC_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_CNT,
      STREAM,
      FINISH
   } state_t;

   typedef struct packed {
      logic                  last;
      logic [DATA_WIDTH-1:0] pos;
   } entry_t;

   state_t state, state_nxt;

   // Read pipeline: one valid bit and address per cycle of RAM latency.
   logic [1:0]                 rd_vld;
   logic [1:0][ADDR_WIDTH-1:0] rd_addr;
   logic [1:0]                 in_flight;

   logic [ADDR_WIDTH-1:0] next_addr;
   logic [ADDR_WIDTH-1:0] issued;
   logic [ADDR_WIDTH-1:0] count;
   logic [ADDR_WIDTH-1:0] cnt_sat;

   entry_t                fifo_mem [FIFO_DEPTH];
   entry_t                head;
   logic [PTR_WIDTH-1:0]  wr_ptr;
   logic [PTR_WIDTH-1:0]  rd_ptr;
   logic [OCC_WIDTH-1:0]  occ;
   logic [CRD_WIDTH-1:0]  credit_used;

   logic issue;
   logic push;
   logic pop;
   logic cnt_hit;
   logic out_valid_int;

   function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
      return (p == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign in_flight     = {1'b0, rd_vld[0]} + {1'b0, rd_vld[1]};
   assign credit_used   = CRD_WIDTH'(occ) + CRD_WIDTH'(in_flight);
   assign cnt_sat       = (mem_q[ADDR_WIDTH-1:0] > MAX_CNT) ? MAX_CNT : mem_q[ADDR_WIDTH-1:0];
   assign cnt_hit       = (state == WAIT_CNT) && rd_vld[1];
   assign push          = (state == STREAM) && rd_vld[1];
   assign out_valid_int = (occ != '0);
   assign pop           = out_valid_int && pos_out.out_ready;
   assign head          = fifo_mem[rd_ptr];

   assign mem_address  = next_addr;
   assign mem_wren     = 1'b0;
   assign mem_data     = '0;
   assign particle_cnt = count;

   // Gated so a reset or an empty FIFO never exposes stale storage.
   assign pos_out.out_valid = out_valid_int;
   assign pos_out.out_pos   = out_valid_int ? head.pos : '0;
   assign pos_out.out_last  = out_valid_int && head.last;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      mem_rden  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               mem_rden  = 1'b1;
               state_nxt = WAIT_CNT;
            end
         end
         WAIT_CNT: begin
            busy = 1'b1;
            if (rd_vld[1]) state_nxt = (cnt_sat == '0) ? FINISH : STREAM;
         end
         STREAM: begin
            busy = 1'b1;
            // Credit check: every in-flight read is guaranteed a FIFO slot.
            if ((issued < count) && (credit_used < CRD_WIDTH'(FIFO_DEPTH))) begin
               issue    = 1'b1;
               mem_rden = 1'b1;
            end
            if (pop && head.last) state_nxt = FINISH;
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld    <= '0;
         rd_addr   <= '0;
         next_addr <= '0;
         issued    <= '0;
         count     <= '0;
      end else begin
         rd_vld  <= {rd_vld[0], mem_rden};
         rd_addr <= {rd_addr[0], mem_address};
         if (cnt_hit) begin
            count     <= cnt_sat;
            next_addr <= ADDR_WIDTH'(1);
            issued    <= '0;
         end else if (issue) begin
            next_addr <= next_addr + 1'b1;
            issued    <= issued + 1'b1;
         end else if (state == FINISH) begin
            next_addr <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         unique case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // NOTE: FIFO storage is deliberately not reset; occupancy and the output
   // gating decide validity, so clearing the array would only cost flops.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= '{last: (rd_addr[1] == count), pos: mem_q};
   end

endmodule

// File: tb/tb_cell_pos_reader.sv
// Self-checking bench for cell_pos_reader: table-driven cells, random cells,
// and hand-written restart / mid-stream reset sequences against a RAM model.
module tb_cell_pos_reader;

   localparam int DW   = 96;
   localparam int PN   = 220;
   localparam int AW   = 8;
   localparam int FD   = 4;
   localparam int MAXC = PN - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] mem_address;
   logic          mem_rden;
   logic          mem_wren;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] mem_q = '0;
   logic [AW-1:0] particle_cnt;
   logic          busy;
   logic          done;

   cell_pos_reader_if #(.DATA_WIDTH(DW)) pos_if ();

   cell_pos_reader #(
      .DATA_WIDTH  (DW),
      .PARTICLE_NUM(PN),
      .ADDR_WIDTH  (AW),
      .FIFO_DEPTH  (FD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .mem_address (mem_address),
      .mem_rden    (mem_rden),
      .mem_wren    (mem_wren),
      .mem_data    (mem_data),
      .mem_q       (mem_q),
      .pos_out     (pos_if),
      .particle_cnt(particle_cnt),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // RAM model: data appears on mem_q two cycles after the rden cycle; junk otherwise.
   logic [DW-1:0] ram [PN];
   logic [DW-1:0] ram_p1 = '0;
   always @(posedge clk) begin
      ram_p1 <= (mem_rden && (int'(mem_address) < PN)) ? ram[mem_address]
                                                        : {$urandom, $urandom, $urandom};
      mem_q  <= ram_p1;
   end

   int cyc_now = 0;
   always @(posedge clk) cyc_now <= cyc_now + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
   } rd_ev_t;

   typedef struct {
      int            cyc;
      logic          last;
      logic [DW-1:0] pos;
   } beat_t;

   rd_ev_t rd_q[$];
   beat_t  beat_q[$];
   int     done_q[$];

   // Monitor, sampled on the falling edge.
   int          rd_stream_n = 0;
   int          beat_n      = 0;
   logic        stall_prev  = 1'b0;
   logic [DW:0] held        = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev  = 1'b0;
         rd_stream_n = beat_n;
      end else begin
         if (stall_prev) begin
            check("hold_valid", pos_if.out_valid, 1);
            check("hold_pos", {pos_if.out_last, pos_if.out_pos}, held);
         end
         if (mem_rden) begin
            rd_q.push_back('{cyc_now, mem_address});
            if (mem_address != '0) begin
               rd_stream_n++;
               check("credit_outstanding", (rd_stream_n - beat_n) <= FD, 1);
            end
         end
         if (pos_if.out_valid && pos_if.out_ready) begin
            beat_q.push_back('{cyc_now, pos_if.out_last, pos_if.out_pos});
            beat_n++;
         end
         if (done) done_q.push_back(cyc_now);
         stall_prev = pos_if.out_valid && !pos_if.out_ready;
         held       = {pos_if.out_last, pos_if.out_pos};
      end
   end

   task automatic load_ram(input logic [AW-1:0] cnt_word, input bit pattern);
      logic [DW-1:0] w;
      w          = {$urandom, $urandom, $urandom};
      w[AW-1:0]  = cnt_word;
      ram[0]     = w;
      for (int i = 1; i < PN; i++)
         ram[i] = pattern ? {32'(i) + 32'h3000_0000, 32'(i) + 32'h2000_0000, 32'(i)}
                          : {$urandom, $urandom, $urandom};
   endtask

   // mode: 0 = ready always high, 1 = random ready, 2 = stall 10 cycles after first valid
   task automatic run_cell(input string tag, input logic [AW-1:0] cnt_word, input int exp_n,
                           input int mode, input bit pattern, input int restart_at);
      int rd_base, beat_base, done_base, s_cyc, cyc, stall_left, n_rd, n_bt;
      bit seen_valid;
      load_ram(cnt_word, pattern);
      rd_base   = rd_q.size();
      beat_base = beat_q.size();
      done_base = done_q.size();
      @(posedge clk); #1;
      start            = 1'b1;
      pos_if.out_ready = (mode == 0);
      s_cyc            = cyc_now;
      check({tag, " busy_at_start"}, busy, 0);
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, " busy_after_start"}, busy, 1);
      cyc        = 1;
      stall_left = 10;
      seen_valid = 1'b0;
      while ((done_q.size() == done_base) && (cyc < 3000)) begin
         case (mode)
            0: pos_if.out_ready = 1'b1;
            1: pos_if.out_ready = 1'($urandom_range(0, 1));
            default: begin
               if (pos_if.out_valid) seen_valid = 1'b1;
               if (seen_valid && (stall_left > 0)) begin
                  pos_if.out_ready = 1'b0;
                  stall_left--;
               end else begin
                  pos_if.out_ready = seen_valid;
               end
            end
         endcase
         start = (cyc == restart_at);
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check({tag, " done_pulses"}, done_q.size() - done_base, 1);
      check({tag, " busy_after_done"}, busy, 0);
      check({tag, " particle_cnt"}, particle_cnt, exp_n);
      check({tag, " mem_wren_mem_data"}, {mem_wren, mem_data}, 0);

      // Expected: one read of word 0, then words 1..n in order, each delivered once.
      n_rd = rd_q.size() - rd_base;
      check({tag, " rd_count"}, n_rd, exp_n + 1);
      if (n_rd > 0) begin
         check({tag, " rd0_addr"}, rd_q[rd_base].addr, 0);
         check({tag, " rd0_cycle"}, rd_q[rd_base].cyc, s_cyc);
      end
      if ((n_rd > 1) && (exp_n > 0))
         check({tag, " first_stream_rd_cycle"}, rd_q[rd_base + 1].cyc, s_cyc + 3);
      for (int k = 1; (k < n_rd) && (k <= exp_n); k++)
         check($sformatf("%s rd_addr[%0d]", tag, k), rd_q[rd_base + k].addr, k);

      n_bt = beat_q.size() - beat_base;
      check({tag, " beat_count"}, n_bt, exp_n);
      for (int k = 0; (k < n_bt) && (k < exp_n); k++) begin
         check($sformatf("%s pos[%0d]", tag, k), beat_q[beat_base + k].pos, ram[k + 1]);
         check($sformatf("%s last[%0d]", tag, k), beat_q[beat_base + k].last, k == exp_n - 1);
         if (mode == 0)
            check($sformatf("%s beat_cycle[%0d]", tag, k), beat_q[beat_base + k].cyc, s_cyc + 6 + k);
      end
      if (done_q.size() > done_base) begin
         if (exp_n == 0)
            check({tag, " done_cycle"}, done_q[done_base], s_cyc + 3);
         else if (n_bt > 0)
            check({tag, " done_cycle"}, done_q[done_base], beat_q[beat_base + n_bt - 1].cyc + 1);
      end
   endtask

   typedef struct {
      logic [AW-1:0] cnt_word;
      int            exp_n;
      int            mode;
      bit            pattern;
      int            restart_at;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int beats0, c;
      logic [AW-1:0] w;

      vecs[0] = '{8'd5,   5,   0, 1'b1, 0};
      vecs[1] = '{8'd0,   0,   0, 1'b1, 0};
      vecs[2] = '{8'd8,   8,   2, 1'b0, 0};
      vecs[3] = '{8'd219, 219, 1, 1'b0, 0};
      vecs[4] = '{8'd250, 219, 1, 1'b0, 0};
      vecs[5] = '{8'd5,   5,   0, 1'b1, 2};
      vecs[6] = '{8'd6,   6,   0, 1'b0, 5};

      pos_if.out_ready = 1'b0;
      for (int i = 0; i < PN; i++) ram[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_out_valid", pos_if.out_valid, 0);
      check("reset_mem_rden", mem_rden, 0);
      check("reset_particle_cnt", particle_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++)
         run_cell($sformatf("vec%0d", i), vecs[i].cnt_word, vecs[i].exp_n,
                  vecs[i].mode, vecs[i].pattern, vecs[i].restart_at);

      // Random cells: expected count is the count word saturated to PARTICLE_NUM-1.
      for (int i = 0; i < 6; i++) begin
         w = 8'($urandom_range(0, 255));
         run_cell($sformatf("rand%0d", i), w, (int'(w) > MAXC) ? MAXC : int'(w), 1, 1'b0, 0);
      end

      // Mid-stream reset after 3 of 6 beats, then a clean 2-particle cell.
      load_ram(8'd6, 1'b1);
      beats0 = beat_q.size();
      @(posedge clk); #1;
      start            = 1'b1;
      pos_if.out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      c = 0;
      while (((beat_q.size() - beats0) < 3) && (c < 100)) begin
         @(posedge clk); #1;
         c++;
      end
      check("rst_beats_before", beat_q.size() - beats0, 3);
      check("rst_pre_valid", pos_if.out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", pos_if.out_valid, 0);
      check("rst_out_pos_last", {pos_if.out_last, pos_if.out_pos}, 0);
      check("rst_busy_done", {busy, done}, 0);
      check("rst_mem_rden", mem_rden, 0);
      check("rst_mem_address", mem_address, 0);
      check("rst_particle_cnt", particle_cnt, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_cell("after_reset", 8'd2, 2, 0, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
